v6_pulse_gen: RTL and testbench
===============================

Name: v6_pulse_gen

Overview:
- Synthetic detector-pulse source producing ADC-format samples: programmable-amplitude steps with exponential decay, riding on a baseline.
- Sits on the ADC side of the v6 shaping filter and drives the filter's ADC sample input in place of the real ADC.
- Lets the bench and on-board self-test stimulate the filter with known, repeatable waveforms.

Parameters:
- ADC_W, 12, output sample width (unsigned).
- FRAC, 16, fractional bits of the decay accumulator.
- ACC_W, ADC_W+FRAC+4, accumulator width; provides pile-up headroom.
- CNT_W, 16, width of the period and pulse-count fields.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; accepted only in IDLE.
- stop  in  1  abort; valid in any state.
- amplitude  in  ADC_W  step height in ADC counts.
- baseline  in  ADC_W  DC offset added to every sample.
- decay_shift  in  4  decay constant; tail multiplies by (1-2^-decay_shift) per cycle.
- period  in  CNT_W  cycles between pulses.
- n_pulses  in  CNT_W  pulses per run; 0 means continuous until stop.
- adc_data  out  ADC_W  registered sample output.
- pulse_strobe  out  1  high on the cycle adc_data contains a new step.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  one-cycle pulse at normal completion.

Behaviour:
- Reset (asynchronous, active-low):
  - state=IDLE; acc=0; counters=0.
  - adc_data=0, pulse_strobe=0, busy=0, done=0.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - adc_data <= baseline each cycle; acc held at 0.
  - On start=1 (and stop=0): latch amplitude, decay_shift, period, n_pulses; set cnt=0, remaining=n_pulses; go to RUN.
  - start outside IDLE is ignored.
- Decay function D(acc):
  - decay_shift=0: D=0 (delta pulses, no tail).
  - Otherwise: D = acc - (acc >> decay_shift), logical shift.
- RUN, every cycle:
  - If cnt==0:
    - acc <= sat(D(acc) + (amplitude << FRAC)); saturates at 2^ACC_W-1.
    - pulse_strobe <= 1.
    - cnt <= max(period,1) - 1.
    - If n_pulses≠0, remaining decrements; if it reaches 0, go to DRAIN.
  - Else: acc <= D(acc); cnt decrements; pulse_strobe <= 0.
- Sample output (RUN and DRAIN):
  - adc_data <= min(baseline + (acc_next >> FRAC), 2^ADC_W-1), where acc_next is the value being written into acc that cycle.
- Latency: start sampled at edge N; first step visible on adc_data, with pulse_strobe, after edge N+1.
- period=0 is treated as 1, giving a pulse every cycle.
- Pile-up: steps add to the remaining tail.
- DRAIN:
  - acc <= D(acc); adc_data computed as in RUN; pulse_strobe=0.
  - When (acc_next >> FRAC)==0: done <= 1 for one cycle, go to IDLE.
  - Termination is guaranteed because decay_shift ≤ 15 < FRAC.
- busy is registered and is high exactly while state is RUN or DRAIN.
- stop (any state, priority over start and pulse injection):
  - Next edge: IDLE, acc=0, adc_data=baseline, pulse_strobe=0, done=0.
  - No completion pulse is generated.
- Config inputs are sampled only at start acceptance; changes mid-run have no effect except baseline, which is live.
- Asynchronous reset mid-run returns to the reset values immediately. Operation resumes only on a new start.

Test Plan:
- Delta pulse: ADC_W=12, baseline=100, amplitude=1000, decay_shift=0, period=5, n_pulses=1 -> adc_data 1100 for one cycle with pulse_strobe; then 100; done one cycle later; busy low afterwards.
- Exponential tail: same, decay_shift=1 -> 1100, 600, 350, 225, 162, ... down to 100; done asserted when the tail integer part reaches 0.
- Pile-up: decay_shift=1, period=1, n_pulses=0 -> 1100, 1600, 1850, 1975, ..., converging to 2100; a strobe every cycle; busy stays high.
- Saturation: baseline=4000, amplitude=500 -> adc_data=4095, never wraps. Start latency: first step exactly one cycle after the start edge.
- Count and spacing: period=10, n_pulses=3, decay_shift=2 -> exactly 3 strobes 10 cycles apart, then DRAIN, then a single done. A start issued during RUN is ignored.
- Abort and reset: assert stop mid-tail -> next cycle adc_data=baseline, busy=0, no done. Assert reset low mid-run -> all outputs 0 asynchronously; idle baseline resumes after reset release.

Source files
------------

// File: rtl/v6_pulse_gen.sv
// Synthetic detector-pulse source: exponential-decay steps on a baseline, in ADC sample format.
// Drives the v6 shaping filter's sample input in place of the real ADC.
module v6_pulse_gen #(
    parameter int ADC_W = 12,
    parameter int FRAC  = 16,
    parameter int ACC_W = ADC_W + FRAC + 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [ADC_W-1:0] amplitude,
    input  logic [ADC_W-1:0] baseline,
    input  logic [3:0]       decay_shift,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] n_pulses,
    output logic [ADC_W-1:0] adc_data,
    output logic             pulse_strobe,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam int INT_W = ACC_W - FRAC;

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   decay;
    logic [ACC_W-1:0]   acc_next;
    logic [ACC_W:0]     sum;
    logic [INT_W:0]     level;
    logic [ADC_W-1:0]   sample;
    logic               tail_zero;
    logic               inject;
    logic [ADC_W-1:0]   amp_l;
    logic [3:0]         shift_l;
    logic [CNT_W-1:0]   period_l;
    logic [CNT_W-1:0]   npulse_l;
    logic [CNT_W-1:0]   period_m1;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   remaining;

    always_comb begin
        inject    = (state == RUN) && (cnt == '0);
        decay     = (shift_l == 4'd0) ? '0 : acc - (acc >> shift_l);
        sum       = {1'b0, decay} + ((ACC_W+1)'(amp_l) << FRAC);
        acc_next  = decay;
        if (inject)
            acc_next = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
        // Integer part of the accumulator plus baseline, clamped to full scale.
        level     = {1'b0, acc_next[ACC_W-1:FRAC]} + (INT_W+1)'(baseline);
        sample    = (|level[INT_W:ADC_W]) ? '1 : level[ADC_W-1:0];
        tail_zero = (acc_next[ACC_W-1:FRAC] == '0);
        period_m1 = (period_l == '0) ? '0 : period_l - 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            acc          <= '0;
            cnt          <= '0;
            remaining    <= '0;
            amp_l        <= '0;
            shift_l      <= '0;
            period_l     <= '0;
            npulse_l     <= '0;
            adc_data     <= '0;
            pulse_strobe <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else if (stop) begin
            state        <= IDLE;
            acc          <= '0;
            cnt          <= '0;
            remaining    <= '0;
            adc_data     <= baseline;
            pulse_strobe <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    acc          <= '0;
                    adc_data     <= baseline;
                    pulse_strobe <= 1'b0;
                    done         <= 1'b0;
                    busy         <= 1'b0;
                    if (start) begin
                        amp_l     <= amplitude;
                        shift_l   <= decay_shift;
                        period_l  <= period;
                        npulse_l  <= n_pulses;
                        cnt       <= '0;
                        remaining <= n_pulses;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    acc      <= acc_next;
                    adc_data <= sample;
                    done     <= 1'b0;
                    if (inject) begin
                        pulse_strobe <= 1'b1;
                        cnt          <= period_m1;
                        if (npulse_l != '0) begin
                            remaining <= remaining - 1'b1;
                            if (remaining == CNT_W'(1))
                                state <= DRAIN;
                        end
                    end else begin
                        pulse_strobe <= 1'b0;
                        cnt          <= cnt - 1'b1;
                    end
                end
                DRAIN: begin
                    acc          <= acc_next;
                    adc_data     <= sample;
                    pulse_strobe <= 1'b0;
                    if (tail_zero) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_v6_pulse_gen.sv
// Randomized bench for v6_pulse_gen: whole-run expected traces are computed from the
// pulse-train arithmetic and consumed one sample per cycle by a single compare process.
module tb_v6_pulse_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic [11:0] amplitude;
    logic [11:0] baseline;
    logic [3:0]  decay_shift;
    logic [15:0] period;
    logic [15:0] n_pulses;
    logic [11:0] adc_data;
    logic        pulse_strobe;
    logic        busy;
    logic        done;

    v6_pulse_gen #(.ADC_W(12), .FRAC(16), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .amplitude(amplitude), .baseline(baseline), .decay_shift(decay_shift),
        .period(period), .n_pulses(n_pulses), .adc_data(adc_data),
        .pulse_strobe(pulse_strobe), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int adc;
        bit strobe;
        bit busy;
        bit done;
    } exp_t;

    exp_t exp_q[$];
    exp_t tr[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input longint act, input longint expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Expected samples for one run: entry 0 is the start-accept edge, entry t+1 is
    // cycle t of the pulse train (pulses at t = k*period for k < n).
    function automatic void build(input int amp, input int base, input int sh,
                                  input int per, input int n, input int maxlen);
        longint acc = 0;
        longint d;
        int     p    = (per == 0) ? 1 : per;
        int     last = (n == 0) ? -1 : (n - 1) * p;
        bit     fin  = 0;
        bit     pulse;
        int     lvl;
        tr.delete();
        tr.push_back('{base, 1'b0, 1'b1, 1'b0});
        for (int t = 0; t < maxlen && !fin; t++) begin
            pulse = ((t % p) == 0) && (n == 0 || (t / p) < n);
            d = (sh == 0) ? 0 : acc - (acc >> sh);
            if (pulse) begin
                acc = d + (longint'(amp) << 16);
                if (acc > 64'hFFFF_FFFF) acc = 64'hFFFF_FFFF;
            end else begin
                acc = d;
            end
            lvl = base + int'(acc >> 16);
            if (lvl > 4095) lvl = 4095;
            fin = (n != 0) && (t > last) && ((acc >> 16) == 0);
            tr.push_back('{lvl, pulse, !fin, fin});
        end
    endfunction

    initial begin : compare
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("adc_data",     adc_data,     e.adc);
                chk("pulse_strobe", pulse_strobe, e.strobe);
                chk("busy",         busy,         e.busy);
                chk("done",         done,         e.done);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            exp_q.push_back('{int'(baseline), 1'b0, 1'b0, 1'b0});
            step();
        end
    endtask

    // One run; stop_at >= 0 aborts after that trace entry. Mid-run, config inputs and
    // start are scrambled to show they are ignored once the run is under way.
    task automatic run(input int amp, input int base, input int sh, input int per,
                       input int n, input int stop_at, input bit scramble);
        int  len;
        bit  do_stop;
        baseline    = 12'(base);
        amplitude   = 12'(amp);
        decay_shift = 4'(sh);
        period      = 16'(per);
        n_pulses    = 16'(n);
        build(amp, base, sh, per, n, (n == 0) ? stop_at + 1 : 3000);
        do_stop = 0;
        if (stop_at >= 0 && stop_at < tr.size() - 1) begin
            while (tr.size() > stop_at + 1) void'(tr.pop_back());
            do_stop = 1;
        end else if (!tr[tr.size()-1].done) begin
            do_stop = 1;
        end
        len = tr.size();
        foreach (tr[i]) exp_q.push_back(tr[i]);
        if (do_stop) exp_q.push_back('{base, 1'b0, 1'b0, 1'b0});
        start = 1'b1;
        for (int i = 0; i < len; i++) begin
            step();
            if (i < len - 1 && scramble) begin
                start       = ($urandom_range(0, 3) == 0);
                amplitude   = 12'($urandom);
                decay_shift = 4'($urandom);
                period      = 16'($urandom_range(0, 30));
                n_pulses    = 16'($urandom_range(0, 5));
            end else begin
                start = 1'b0;
            end
        end
        if (do_stop) begin
            stop = 1'b1;
            step();
            stop = 1'b0;
        end
    endtask

    initial begin : stim
        int strobes;
        reset = 1'b0; start = 1'b0; stop = 1'b0;
        amplitude = '0; baseline = 12'd100; decay_shift = '0; period = '0; n_pulses = '0;
        #1;
        chk("reset_adc",  adc_data, 0);
        chk("reset_busy", busy, 0);
        repeat (2) step();
        reset = 1'b1;
        idle(3);

        // Delta pulse
        run(1000, 100, 0, 5, 1, -1, 0);
        chk("delta_step", tr[1].adc, 1100);
        chk("delta_next", tr[2].adc, 100);
        chk("delta_done", tr[2].done, 1);
        chk("delta_len",  tr.size(), 3);
        idle(2);

        // Exponential tail
        run(1000, 100, 1, 5, 1, -1, 0);
        chk("tail_1", tr[1].adc, 1100);
        chk("tail_2", tr[2].adc, 600);
        chk("tail_3", tr[3].adc, 350);
        chk("tail_4", tr[4].adc, 225);
        chk("tail_5", tr[5].adc, 162);
        chk("tail_end", tr[tr.size()-1].adc, 100);
        idle(2);

        // Pile-up, continuous, aborted
        run(1000, 100, 1, 1, 0, 40, 0);
        chk("pile_1", tr[1].adc, 1100);
        chk("pile_2", tr[2].adc, 1600);
        chk("pile_3", tr[3].adc, 1850);
        chk("pile_4", tr[4].adc, 1975);
        chk("pile_40", tr[40].adc, 2100);
        idle(2);

        // Saturation of the output clamp
        run(500, 4000, 3, 4, 2, -1, 0);
        chk("sat_1", tr[1].adc, 4095);
        chk("sat_strobe", tr[1].strobe, 1);
        idle(2);

        // Count and spacing with a start issued mid-run
        run(800, 50, 2, 10, 3, -1, 1);
        strobes = 0;
        foreach (tr[i]) strobes += int'(tr[i].strobe);
        chk("count_strobes", strobes, 3);
        chk("count_third", tr[21].strobe, 1);
        idle(2);

        // Abort mid-tail
        run(1000, 100, 4, 5, 1, 8, 0);
        idle(2);

        for (int r = 0; r < 30; r++) begin
            int sa;
            sa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 60)) : -1;
            run(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
                int'($urandom_range(0, 6)), int'($urandom_range(0, 20)),
                int'($urandom_range(0, 4)), (sa < 0 && $urandom_range(0, 4) == 0) ? 200 : sa,
                $urandom_range(0, 1) == 1);
            idle(int'($urandom_range(1, 3)));
        end

        // Asynchronous reset mid-run
        baseline = 12'd300; amplitude = 12'd900; decay_shift = 4'd3;
        period = 16'd4; n_pulses = 16'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        reset = 1'b0;
        #1;
        chk("arst_adc",    adc_data, 0);
        chk("arst_strobe", pulse_strobe, 0);
        chk("arst_busy",   busy, 0);
        chk("arst_done",   done, 0);
        #2;
        reset = 1'b1;
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests);
        $fatal(1);
    end

endmodule
